// File: rtl/histogram_cdf_if.sv
// Bin-count input stream (r*) and cumulative-count output stream (t*) of the CDF stage.
// The slave modport is the CDF stage's view; master is the surrounding system.
interface histogram_cdf_if #(
  parameter int P_DW = 4,
  parameter int P_OW = 7
);
  logic [P_DW-1:0] rdata;
  logic            rvalid;
  logic            rlast;
  logic            rready;
  logic [P_OW-1:0] tdata;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport slave (
    input  rdata, rvalid, rlast, tready,
    output rready, tdata, tvalid, tlast
  );

  modport master (
    output rdata, rvalid, rlast, tready,
    input  rready, tdata, tvalid, tlast
  );
endinterface

// File: rtl/histogram_cdf.sv
// Running cumulative sum of histogram bin counts with saturation, framing check and
// end-of-frame interrupt; one-deep registered output stage.
module histogram_cdf #(
  parameter int P_DW      = 4,
  parameter int P_NUM_BIN = 8,
  parameter int P_OW      = 7
) (
  input  logic           aclk,
  input  logic           areset,
  histogram_cdf_if.slave bus,
  output logic           frame_err,
  output logic           interrupt_out
);
  localparam int              CW       = $clog2(P_NUM_BIN);
  localparam logic [CW-1:0]   LAST_BIN = CW'(P_NUM_BIN - 1);
  localparam logic [P_OW-1:0] SAT_MAX  = '1;
  localparam logic [0:0]      S_ACC    = 1'b0;
  localparam logic [0:0]      S_DRAIN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [P_OW-1:0] acc_q, acc_d;
  logic [P_OW-1:0] tdata_q, tdata_d;
  logic [CW-1:0]   bin_cnt_q, bin_cnt_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            frame_err_q, frame_err_d;
  logic            irq_q, irq_d;

  logic            rready_int;
  logic            accept;
  logic            t_hs;
  logic            at_last_bin;
  logic            eof;
  logic [P_OW:0]   sum_wide;
  logic [P_OW-1:0] sum_sat;

  // Input is stalled while draining a frame or while a held beat is not being taken.
  assign rready_int  = (state_q == S_ACC) && (!tvalid_q || bus.tready);
  assign accept      = bus.rvalid && rready_int;
  assign t_hs        = tvalid_q && bus.tready;
  assign at_last_bin = (bin_cnt_q == LAST_BIN);
  assign eof         = bus.rlast || at_last_bin;
  assign sum_wide    = {1'b0, acc_q} + (P_OW + 1)'(bus.rdata);
  assign sum_sat     = sum_wide[P_OW] ? SAT_MAX : sum_wide[P_OW-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tdata_d     = tdata_q;
    bin_cnt_d   = bin_cnt_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    // Error when rlast and the bin counter disagree about where the frame ends.
    frame_err_d = accept && (bus.rlast != at_last_bin);
    irq_d       = t_hs && tlast_q;

    if (accept) begin
      tdata_d  = sum_sat;
      tvalid_d = 1'b1;
      tlast_d  = eof;
      if (eof) begin
        acc_d     = '0;
        bin_cnt_d = '0;
        state_d   = S_DRAIN;
      end else begin
        acc_d     = sum_sat;
        bin_cnt_d = bin_cnt_q + CW'(1);
      end
    end else if (t_hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      if (state_q == S_DRAIN && tlast_q) begin
        state_d = S_ACC;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      tdata_q     <= '0;
      bin_cnt_q   <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tdata_q     <= tdata_d;
      bin_cnt_q   <= bin_cnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.rready    = rready_int;
  assign bus.tdata     = tdata_q;
  assign bus.tvalid    = tvalid_q;
  assign bus.tlast     = tlast_q;
  assign frame_err     = frame_err_q;
  assign interrupt_out = irq_q;
endmodule

// File: tb/tb_histogram_cdf.sv
// Table-driven bench for histogram_cdf: vectors feed a scoreboard checked on output handshakes,
// plus hand sequences for reset abort and saturation (second instance with P_OW=5).
module tb_histogram_cdf;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  histogram_cdf_if #(.P_DW(4), .P_OW(7)) bus_a ();
  histogram_cdf_if #(.P_DW(4), .P_OW(5)) bus_b ();
  logic ferr_a, irq_a, ferr_b, irq_b;

  histogram_cdf #(.P_DW(4), .P_NUM_BIN(8), .P_OW(7)) dut_a (
    .aclk(aclk), .areset(areset), .bus(bus_a), .frame_err(ferr_a), .interrupt_out(irq_a)
  );
  histogram_cdf #(.P_DW(4), .P_NUM_BIN(8), .P_OW(5)) dut_b (
    .aclk(aclk), .areset(areset), .bus(bus_b), .frame_err(ferr_b), .interrupt_out(irq_b)
  );

  typedef struct {
    logic [3:0] d;
    logic       l;
    logic [6:0] et;
    logic       el;
  } vec_t;
  typedef struct {
    logic [6:0] t;
    logic       l;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ferr_cnt = 0;
  int   irq_cnt = 0;
  logic tr_mode = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int d, input bit l, input int et, input bit el);
    vec_t v;
    v.d = 4'(d); v.l = l; v.et = 7'(et); v.el = el;
    vecs.push_back(v);
  endfunction

  // tready is either held high or toggled every cycle.
  initial begin
    bus_a.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (tr_mode) bus_a.tready = ~bus_a.tready;
      else         bus_a.tready = 1'b1;
    end
  end

  // Output monitor for instance A.
  initial begin
    logic       prev_stall = 1'b0;
    logic [6:0] prev_t = '0;
    logic       prev_l = 1'b0;
    logic       irq_exp = 1'b0;
    exp_t       e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
        irq_exp    = 1'b0;
      end else begin
        chk("irq_timing", int'(irq_a), int'(irq_exp));
        if (prev_stall) begin
          chk("hold_tvalid", int'(bus_a.tvalid), 1);
          chk("hold_tdata", int'(bus_a.tdata), int'(prev_t));
          chk("hold_tlast", int'(bus_a.tlast), int'(prev_l));
        end
        if (bus_a.tvalid && (bus_a.tlast || !bus_a.tready))
          chk("rready_rule", int'(bus_a.rready), 0);
        if (ferr_a) ferr_cnt++;
        if (irq_a)  irq_cnt++;
        if (bus_a.tvalid && bus_a.tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", int'(bus_a.tdata), -1);
          end else begin
            e = sb.pop_front();
            chk("tdata", int'(bus_a.tdata), int'(e.t));
            chk("tlast", int'(bus_a.tlast), int'(e.l));
          end
        end
        irq_exp    = bus_a.tvalid && bus_a.tready && bus_a.tlast;
        prev_stall = bus_a.tvalid && !bus_a.tready;
        prev_t     = bus_a.tdata;
        prev_l     = bus_a.tlast;
      end
    end
  end

  task automatic send(input vec_t v);
    bit   ok = 1'b0;
    exp_t e;
    bus_a.rdata  = v.d;
    bus_a.rlast  = v.l;
    bus_a.rvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (bus_a.rready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.t = v.et; e.l = v.el;
      sb.push_back(e);
    end
    @(posedge aclk); #1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(vecs[i]);
    bus_a.rvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (sb.size() == 0 && !bus_a.tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  initial begin
    int s1, s2, s3, s4, s5, s6, s7;
    int d2[8];
    int e2[8];
    int eb[8];
    d2 = '{3, 0, 15, 2, 1, 1, 1, 1};
    e2 = '{3, 3, 18, 20, 21, 22, 23, 24};
    eb = '{15, 30, 31, 31, 31, 31, 31, 31};

    s1 = vecs.size();
    for (int k = 0; k < 8; k++) add(1, k == 7, k + 1, k == 7);
    s2 = vecs.size();
    for (int k = 0; k < 8; k++) add(d2[k], k == 7, e2[k], k == 7);
    s3 = vecs.size();
    add(1, 0, 1, 0); add(2, 0, 3, 0); add(3, 1, 6, 1);
    s4 = vecs.size();
    for (int k = 0; k < 8; k++) add(2, 0, 2 * (k + 1), k == 7);
    add(5, 0, 5, 0);
    for (int k = 1; k < 8; k++) add(0, k == 7, 5, k == 7);
    s5 = vecs.size();
    add(1, 0, 1, 0); add(2, 0, 3, 0); add(3, 0, 6, 0); add(4, 0, 10, 0);
    s6 = vecs.size();
    for (int k = 0; k < 8; k++) add(2, k == 7, 2 * (k + 1), k == 7);
    s7 = vecs.size();

    areset = 1'b1;
    bus_a.rvalid = 1'b0; bus_a.rdata = '0; bus_a.rlast = 1'b0;
    bus_b.rvalid = 1'b0; bus_b.rdata = '0; bus_b.rlast = 1'b0; bus_b.tready = 1'b1;
    repeat (3) @(posedge aclk); #1;
    chk("rst_tvalid", int'(bus_a.tvalid), 0);
    chk("rst_tlast", int'(bus_a.tlast), 0);
    chk("rst_tdata", int'(bus_a.tdata), 0);
    chk("rst_frame_err", int'(ferr_a), 0);
    chk("rst_irq", int'(irq_a), 0);
    chk("rst_rready", int'(bus_a.rready), 1);
    areset = 1'b0;
    @(posedge aclk); #1;

    run(s1, s2); drain();
    chk("t1_ferr_cnt", ferr_cnt, 0); chk("t1_irq_cnt", irq_cnt, 1);

    tr_mode = 1'b1;
    run(s2, s3); drain();
    tr_mode = 1'b0;
    chk("t2_ferr_cnt", ferr_cnt, 0); chk("t2_irq_cnt", irq_cnt, 2);

    run(s3, s4); drain();
    chk("t3_ferr_cnt", ferr_cnt, 1); chk("t3_irq_cnt", irq_cnt, 3);

    run(s4, s5); drain();
    chk("t4_ferr_cnt", ferr_cnt, 2); chk("t4_irq_cnt", irq_cnt, 5);

    // Abort a frame mid-way with a beat pending on the output.
    run(s5, s6);
    chk("t6_pre_tvalid", int'(bus_a.tvalid), 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("t6_tvalid", int'(bus_a.tvalid), 0);
    chk("t6_tlast", int'(bus_a.tlast), 0);
    chk("t6_tdata", int'(bus_a.tdata), 0);
    chk("t6_frame_err", int'(ferr_a), 0);
    chk("t6_irq", int'(irq_a), 0);
    sb.delete();
    areset = 1'b0;
    @(posedge aclk); #1;
    run(s6, s7); drain();
    chk("t6_ferr_cnt", ferr_cnt, 2); chk("t6_irq_cnt", irq_cnt, 6);

    // Saturation on the narrow-output instance.
    for (int k = 0; k < 8; k++) begin
      bus_b.rdata  = 4'd15;
      bus_b.rlast  = (k == 7);
      bus_b.rvalid = 1'b1;
      @(posedge aclk); #1;
      chk($sformatf("sat_tdata_%0d", k), int'(bus_b.tdata), eb[k]);
      chk($sformatf("sat_tlast_%0d", k), int'(bus_b.tlast), (k == 7) ? 1 : 0);
      chk($sformatf("sat_ferr_%0d", k), int'(ferr_b), 0);
    end
    bus_b.rvalid = 1'b0;
    chk("sat_drain_rready", int'(bus_b.rready), 0);
    @(posedge aclk); #1;
    chk("sat_irq", int'(irq_b), 1);
    chk("sat_tvalid_clear", int'(bus_b.tvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
